// File: rtl/ovl_change_window_checker.sv
// Change-window evaluation stage.
// Consumes the upstream window/window_close flags together with start_event
// and test_expr. It reports a window that closed without test_expr changing,
// and a start event that arrived while a window was open (error mode only).
// It also keeps saturating coverage counters.
//
// Ports:
//   clk            rising-edge sampling clock
//   reset_n        synchronous active-low reset
//   start_event    start of a change window
//   test_expr      expression that must change inside the window
//   window         upstream window-open flag
//   window_close   upstream last-cycle-of-window flag (valid while window=1)
//   fire_no_change one-cycle pulse: window closed with no change
//   fire_new_start one-cycle pulse: start during open window (action 2)
//   err_param      illegal parameter value, held high out of reset
//   cov_opened     windows opened (saturating)
//   cov_restarted  windows restarted (saturating, action 1 only)
//   cov_changed    windows closed with a change seen (saturating)
module ovl_change_window_checker #(
    parameter int width               = 8,
    parameter int num_cks             = 2,
    parameter int action_on_new_start = 0,
    parameter int cnt_width           = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_event,
    input  logic [width-1:0]     test_expr,
    input  logic                 window,
    input  logic                 window_close,
    output logic                 fire_no_change,
    output logic                 fire_new_start,
    output logic                 err_param,
    output logic [cnt_width-1:0] cov_opened,
    output logic [cnt_width-1:0] cov_restarted,
    output logic [cnt_width-1:0] cov_changed
);

    localparam int unsigned CW = cnt_width;
    localparam logic        PARAM_BAD = (action_on_new_start > 2) || (num_cks < 1);
    localparam logic        ACT_RESET = (action_on_new_start == 1);
    localparam logic        ACT_ERROR = (action_on_new_start == 2);

    logic [width-1:0] r_prev;
    logic             r_seen;
    logic             r_fire_no_change;
    logic             r_fire_new_start;
    logic             r_err_param;
    logic [CW-1:0]    r_cov_opened;
    logic [CW-1:0]    r_cov_restarted;
    logic [CW-1:0]    r_cov_changed;

    logic w_delta;
    logic w_open;
    logic w_restart;
    logic w_hit;
    logic w_close;
    logic w_new_start;

    // Per-edge event decode; a restart suppresses the close evaluation.
    always_comb begin
        w_delta     = (test_expr != r_prev);
        w_open      = !window && start_event;
        w_restart   = window && ACT_RESET && start_event;
        w_hit       = r_seen || w_delta;
        w_close     = window && !w_restart && window_close;
        w_new_start = window && ACT_ERROR && start_event;
    end

    // Previous-value sampler runs through reset so the first window edge
    // compares against a real value.
    always_ff @(posedge clk) begin
        r_prev <= test_expr;
    end

    // Window tracking, fire pulses and coverage counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_seen           <= 1'b0;
            r_fire_no_change <= 1'b0;
            r_fire_new_start <= 1'b0;
            r_err_param      <= 1'b0;
            r_cov_opened     <= '0;
            r_cov_restarted  <= '0;
            r_cov_changed    <= '0;
        end else begin
            r_err_param      <= PARAM_BAD;
            r_fire_no_change <= !PARAM_BAD && w_close && !w_hit;
            r_fire_new_start <= !PARAM_BAD && w_new_start;

            if (w_open) begin
                r_seen <= 1'b0;
            end else if (window) begin
                if (w_restart || w_close) begin
                    r_seen <= 1'b0;
                end else begin
                    r_seen <= w_hit;
                end
            end

            if (w_open && (r_cov_opened != '1)) begin
                r_cov_opened <= r_cov_opened + CW'(1);
            end
            if (w_restart && (r_cov_restarted != '1)) begin
                r_cov_restarted <= r_cov_restarted + CW'(1);
            end
            if (w_close && w_hit && (r_cov_changed != '1)) begin
                r_cov_changed <= r_cov_changed + CW'(1);
            end
        end
    end

    assign fire_no_change = r_fire_no_change;
    assign fire_new_start = r_fire_new_start;
    assign err_param      = r_err_param;
    assign cov_opened     = r_cov_opened;
    assign cov_restarted  = r_cov_restarted;
    assign cov_changed    = r_cov_changed;

endmodule

// File: tb/tb_ovl_change_window_checker.sv
// Directed bench for ovl_change_window_checker. Five instances share the
// stimulus: action 0, 1, 2, 3 (illegal) with num_cks=3, and action 0 with
// 2-bit counters. Each scenario starts from reset; window/window_close are
// driven directly as the upstream generator would produce them.
module tb_ovl_change_window_checker;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_event = 1'b0;
    logic [7:0] test_expr = 8'h10;
    logic       window = 1'b0;
    logic       window_close = 1'b0;

    logic        fnc0, fns0, err0;
    logic [31:0] op0, rs0, ch0;
    logic        fnc1, fns1, err1;
    logic [31:0] op1, rs1, ch1;
    logic        fnc2, fns2, err2;
    logic [31:0] op2, rs2, ch2;
    logic        fnc3, fns3, err3;
    logic [31:0] op3, rs3, ch3;
    logic        fnc4, fns4, err4;
    logic [1:0]  op4, rs4, ch4;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ovl_change_window_checker #(.width(8), .num_cks(3), .action_on_new_start(0), .cnt_width(32)) dut0 (
        .clk(clk), .reset_n(reset_n), .start_event(start_event), .test_expr(test_expr),
        .window(window), .window_close(window_close), .fire_no_change(fnc0),
        .fire_new_start(fns0), .err_param(err0), .cov_opened(op0),
        .cov_restarted(rs0), .cov_changed(ch0));

    ovl_change_window_checker #(.width(8), .num_cks(3), .action_on_new_start(1), .cnt_width(32)) dut1 (
        .clk(clk), .reset_n(reset_n), .start_event(start_event), .test_expr(test_expr),
        .window(window), .window_close(window_close), .fire_no_change(fnc1),
        .fire_new_start(fns1), .err_param(err1), .cov_opened(op1),
        .cov_restarted(rs1), .cov_changed(ch1));

    ovl_change_window_checker #(.width(8), .num_cks(3), .action_on_new_start(2), .cnt_width(32)) dut2 (
        .clk(clk), .reset_n(reset_n), .start_event(start_event), .test_expr(test_expr),
        .window(window), .window_close(window_close), .fire_no_change(fnc2),
        .fire_new_start(fns2), .err_param(err2), .cov_opened(op2),
        .cov_restarted(rs2), .cov_changed(ch2));

    ovl_change_window_checker #(.width(8), .num_cks(3), .action_on_new_start(3), .cnt_width(32)) dut3 (
        .clk(clk), .reset_n(reset_n), .start_event(start_event), .test_expr(test_expr),
        .window(window), .window_close(window_close), .fire_no_change(fnc3),
        .fire_new_start(fns3), .err_param(err3), .cov_opened(op3),
        .cov_restarted(rs3), .cov_changed(ch3));

    ovl_change_window_checker #(.width(8), .num_cks(3), .action_on_new_start(0), .cnt_width(2)) dut4 (
        .clk(clk), .reset_n(reset_n), .start_event(start_event), .test_expr(test_expr),
        .window(window), .window_close(window_close), .fire_no_change(fnc4),
        .fire_new_start(fns4), .err_param(err4), .cov_opened(op4),
        .cov_restarted(rs4), .cov_changed(ch4));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one edge's inputs, let the edge happen, sample 1 time unit later.
    task automatic step(input logic se, input logic [7:0] te, input logic win, input logic wc);
        start_event  = se;
        test_expr    = te;
        window       = win;
        window_close = wc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(1'b0, 8'h10, 1'b0, 1'b0);
        step(1'b0, 8'h10, 1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_fnc0", 64'(fnc0), 64'd0);
        check("rst_fns2", 64'(fns2), 64'd0);
        check("rst_err3", 64'(err3), 64'd0);
        check("rst_op0", 64'(op0), 64'd0);
        check("rst_rs1", 64'(rs1), 64'd0);
        check("rst_ch0", 64'(ch0), 64'd0);

        // A: action 0, no change through E3 -> fire after E3 only
        step(1'b1, 8'h10, 1'b0, 1'b0);              // E0
        check("A_op0_e0", 64'(op0), 64'd1);
        check("A_err0", 64'(err0), 64'd0);
        check("A_err3", 64'(err3), 64'd1);
        step(1'b0, 8'h10, 1'b1, 1'b0);              // E1
        check("A_fnc0_e1", 64'(fnc0), 64'd0);
        step(1'b0, 8'h10, 1'b1, 1'b0);              // E2
        step(1'b0, 8'h10, 1'b1, 1'b1);              // E3
        check("A_fnc0_e3", 64'(fnc0), 64'd1);
        check("A_fnc3_e3", 64'(fnc3), 64'd0);
        check("A_err3_e3", 64'(err3), 64'd1);
        step(1'b0, 8'h10, 1'b0, 1'b0);
        check("A_fnc0_after", 64'(fnc0), 64'd0);
        check("A_ch0", 64'(ch0), 64'd0);
        check("A_op0", 64'(op0), 64'd1);

        // B: change before E2 satisfies the window; then a glitch window
        do_reset();
        step(1'b1, 8'h10, 1'b0, 1'b0);              // E0
        step(1'b0, 8'h10, 1'b1, 1'b0);              // E1
        step(1'b0, 8'h11, 1'b1, 1'b0);              // E2 change
        step(1'b0, 8'h11, 1'b1, 1'b1);              // E3
        check("B_fnc0_e3", 64'(fnc0), 64'd0);
        check("B_ch0_e3", 64'(ch0), 64'd1);
        step(1'b1, 8'h10, 1'b0, 1'b0);              // E0 (change at open is ignored)
        step(1'b0, 8'h10, 1'b1, 1'b0);              // E1
        step(1'b0, 8'h11, 1'b1, 1'b0);              // E2 glitch up
        step(1'b0, 8'h10, 1'b1, 1'b1);              // E3 glitch back
        check("B_glitch_fnc0", 64'(fnc0), 64'd0);
        check("B_glitch_ch0", 64'(ch0), 64'd2);
        check("B_op0", 64'(op0), 64'd2);

        // C: action 2, start at E2 -> new-start pulse, window still evaluated
        do_reset();
        step(1'b1, 8'h10, 1'b0, 1'b0);              // E0
        step(1'b0, 8'h10, 1'b1, 1'b0);              // E1
        step(1'b1, 8'h10, 1'b1, 1'b0);              // E2 with start
        check("C_fns2_e2", 64'(fns2), 64'd1);
        check("C_fns0_e2", 64'(fns0), 64'd0);
        check("C_fnc2_e2", 64'(fnc2), 64'd0);
        step(1'b0, 8'h10, 1'b1, 1'b1);              // E3
        check("C_fns2_e3", 64'(fns2), 64'd0);
        check("C_fnc2_e3", 64'(fnc2), 64'd1);
        check("C_op2", 64'(op2), 64'd1);
        // second window: close and start on the same edge -> both pulses
        step(1'b1, 8'h10, 1'b0, 1'b0);              // E0
        step(1'b0, 8'h10, 1'b1, 1'b0);              // E1
        step(1'b0, 8'h10, 1'b1, 1'b0);              // E2
        step(1'b1, 8'h10, 1'b1, 1'b1);              // E3 with start
        check("C_both_fnc2", 64'(fnc2), 64'd1);
        check("C_both_fns2", 64'(fns2), 64'd1);
        check("C_both_op2", 64'(op2), 64'd2);

        // D: action 1, restart at E3 with a change that must be discarded
        do_reset();
        step(1'b1, 8'h10, 1'b0, 1'b0);              // E0
        step(1'b0, 8'h10, 1'b1, 1'b0);              // E1
        step(1'b0, 8'h10, 1'b1, 1'b0);              // E2
        step(1'b1, 8'h11, 1'b1, 1'b1);              // E3 restart + change
        check("D_fnc1_e3", 64'(fnc1), 64'd0);
        check("D_rs1_e3", 64'(rs1), 64'd1);
        check("D_ch1_e3", 64'(ch1), 64'd0);
        step(1'b0, 8'h11, 1'b1, 1'b0);              // E4
        step(1'b0, 8'h11, 1'b1, 1'b0);              // E5
        check("D_fnc1_e5", 64'(fnc1), 64'd0);
        step(1'b0, 8'h11, 1'b1, 1'b1);              // E6
        check("D_fnc1_e6", 64'(fnc1), 64'd1);
        check("D_ch1_e6", 64'(ch1), 64'd0);
        check("D_op1", 64'(op1), 64'd1);

        // E: reset at E2 discards the window
        do_reset();
        step(1'b1, 8'h10, 1'b0, 1'b0);              // E0
        step(1'b0, 8'h10, 1'b1, 1'b0);              // E1
        reset_n = 1'b0;
        step(1'b0, 8'h10, 1'b1, 1'b0);              // E2 in reset
        reset_n = 1'b1;
        check("E_op0_rst", 64'(op0), 64'd0);
        check("E_fnc0_rst", 64'(fnc0), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h10, 1'b0, 1'b0);
            check("E_fnc0_idle", 64'(fnc0), 64'd0);
        end
        check("E_op0_end", 64'(op0), 64'd0);

        // F: 2-bit counter saturates at 3 after 5 opens
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 8'h10, 1'b0, 1'b0);
            check("F_op4", 64'(op4), (i < 3) ? 64'(i) : 64'd3);
        end
        check("F_op0", 64'(op0), 64'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
